// File: rtl/addsub_issue_ctrl.sv
// addsub_issue_ctrl
//   Command sequencer and result-capture stage around a 32-bit combinational
//   adder/subtractor. A command is accepted over a valid/ready handshake; its
//   operands are registered onto the adder and held for SETTLE_CYCLES edges.
//   The adder output is then captured, optionally saturated, into a response
//   register. ACC ops use and update a 32-bit accumulator and a sticky overflow flag.
//
//   state | meaning
//   IDLE  | ready for a command (cmd_ready=1)
//   ISSUE | operands held on the adder, settle counter running
//   RESP  | response held until the consumer takes it
//
// Ports
//   clk, rst_n                    clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_op[1:0]                   00 ADD, 01 SUB, 10 ACC_ADD, 11 ACC_SUB
//   cmd_a, cmd_b                  operands (cmd_a ignored for ACC ops)
//   alu_a, alu_b, alu_sub         registered drive to the adder
//   alu_result, alu_pos_ovf/neg   adder outputs
//   rsp_valid/rsp_ready           response handshake
//   rsp_result, rsp_pos/neg_ovf   captured response
//   acc_clear                     synchronous clear of accumulator and sticky flag
//   acc_value, sticky_ovf         accumulator state
module addsub_issue_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter bit          SATURATE      = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [31:0] cmd_a,
   input  logic [31:0] cmd_b,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic        alu_sub,
   input  logic [31:0] alu_result,
   input  logic        alu_pos_ovf,
   input  logic        alu_neg_ovf,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic        rsp_pos_ovf,
   output logic        rsp_neg_ovf,
   input  logic        acc_clear,
   output logic [31:0] acc_value,
   output logic        sticky_ovf
);

   localparam int unsigned CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             acc_op;
   logic             accept;
   logic             capture;
   logic             rsp_done;
   logic [31:0]      sat_result;

   assign accept   = cmd_valid & cmd_ready;
   assign capture  = (state == ISSUE) && (cnt == CNT_W'(1));
   assign rsp_done = rsp_valid & rsp_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)   state_nxt = ISSUE;
         ISSUE:   if (capture)  state_nxt = RESP;
         RESP:    if (rsp_done) state_nxt = IDLE;
         default:               state_nxt = IDLE;
      endcase
   end

   always_comb begin
      sat_result = alu_result;
      if (SATURATE) begin
         if (alu_pos_ovf)      sat_result = 32'h7FFF_FFFF;
         else if (alu_neg_ovf) sat_result = 32'h8000_0000;
      end
   end

   // cmd_ready is registered so it stays low while in reset and for the first
   // cycle after release, then tracks "next state is IDLE".
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_ready   <= 1'b0;
         cnt         <= '0;
         acc_op      <= 1'b0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_sub     <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_result  <= '0;
         rsp_pos_ovf <= 1'b0;
         rsp_neg_ovf <= 1'b0;
         acc_value   <= '0;
         sticky_ovf  <= 1'b0;
      end else begin
         cmd_ready <= (state_nxt == IDLE);

         if (accept) begin
            alu_a   <= cmd_op[1] ? acc_value : cmd_a;
            alu_b   <= cmd_b;
            alu_sub <= cmd_op[0];
            acc_op  <= cmd_op[1];
            cnt     <= CNT_INIT;
         end else if ((state == ISSUE) && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
         end

         if (capture) begin
            rsp_valid   <= 1'b1;
            rsp_result  <= sat_result;
            rsp_pos_ovf <= alu_pos_ovf;
            rsp_neg_ovf <= alu_neg_ovf;
            if (acc_op) begin
               acc_value  <= sat_result;
               sticky_ovf <= sticky_ovf | alu_pos_ovf | alu_neg_ovf;
            end
         end else if (rsp_done) begin
            rsp_valid <= 1'b0;
         end

         // Clear overrides any accumulator update on the same edge.
         if (acc_clear) begin
            acc_value  <= '0;
            sticky_ovf <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_addsub_issue_ctrl.sv
// Bench for addsub_issue_ctrl: two instances (SATURATE=0 and SATURATE=1)
// driven by the same stimulus, each wrapped around a behavioural adder.
module tb_addsub_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, rsp_ready, acc_clear;
   logic [1:0]  cmd_op;
   logic [31:0] cmd_a, cmd_b;

   logic        cmd_ready [2];
   logic [31:0] alu_a [2];
   logic [31:0] alu_b [2];
   logic        alu_sub [2];
   logic [31:0] alu_result [2];
   logic        alu_pos_ovf [2];
   logic        alu_neg_ovf [2];
   logic        rsp_valid [2];
   logic [31:0] rsp_result [2];
   logic        rsp_pos_ovf [2];
   logic        rsp_neg_ovf [2];
   logic [31:0] acc_value [2];
   logic        sticky_ovf [2];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [31:0] bb;
      assign bb              = alu_sub[g] ? ~alu_b[g] : alu_b[g];
      assign alu_result[g]   = alu_a[g] + bb + {31'd0, alu_sub[g]};
      assign alu_pos_ovf[g]  = ~alu_a[g][31] & ~bb[31] &  alu_result[g][31];
      assign alu_neg_ovf[g]  =  alu_a[g][31] &  bb[31] & ~alu_result[g][31];

      addsub_issue_ctrl #(
         .SETTLE_CYCLES (2),
         .SATURATE      ((g == 1) ? 1'b1 : 1'b0)
      ) u_dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .cmd_valid   (cmd_valid),
         .cmd_ready   (cmd_ready[g]),
         .cmd_op      (cmd_op),
         .cmd_a       (cmd_a),
         .cmd_b       (cmd_b),
         .alu_a       (alu_a[g]),
         .alu_b       (alu_b[g]),
         .alu_sub     (alu_sub[g]),
         .alu_result  (alu_result[g]),
         .alu_pos_ovf (alu_pos_ovf[g]),
         .alu_neg_ovf (alu_neg_ovf[g]),
         .rsp_valid   (rsp_valid[g]),
         .rsp_ready   (rsp_ready),
         .rsp_result  (rsp_result[g]),
         .rsp_pos_ovf (rsp_pos_ovf[g]),
         .rsp_neg_ovf (rsp_neg_ovf[g]),
         .acc_clear   (acc_clear),
         .acc_value   (acc_value[g]),
         .sticky_ovf  (sticky_ovf[g])
      );
   end

   typedef struct {
      logic [1:0]       op;
      logic [31:0]      a;
      logic [31:0]      b;
      int               stall;
      logic             clr;
      logic [1:0][31:0] res;   // index = instance (0: wrap, 1: saturate)
      logic [1:0]       pos;
      logic [1:0]       neg;
      logic [1:0][31:0] acc;
      logic [1:0]       sticky;
   } vec_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] acc_m [2];
   logic        sticky_m [2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input int st, input logic clr,
                               input logic [31:0] r0, input logic [31:0] r1,
                               input logic [1:0] p, input logic [1:0] n,
                               input logic [31:0] a0, input logic [31:0] a1, input logic [1:0] s);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.stall = st; v.clr = clr;
      v.res[0] = r0; v.res[1] = r1; v.pos = p; v.neg = n;
      v.acc[0] = a0; v.acc[1] = a1; v.sticky = s;
      return v;
   endfunction

   // Reference: exact signed arithmetic in 64 bits, overflow = result out of int32 range.
   function automatic vec_t predict(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input int st, input logic clr);
      vec_t        v;
      longint      x, y, full;
      logic        p, n;
      logic [31:0] r;
      v.op = op; v.a = a; v.b = b; v.stall = st; v.clr = clr;
      for (int i = 0; i < 2; i++) begin
         x    = longint'(signed'(op[1] ? acc_m[i] : a));
         y    = longint'(signed'(b));
         full = op[0] ? (x - y) : (x + y);
         p    = (full > 64'sd2147483647);
         n    = (full < -64'sd2147483648);
         r    = full[31:0];
         if (i == 1 && p)      r = 32'h7FFF_FFFF;
         else if (i == 1 && n) r = 32'h8000_0000;
         v.res[i] = r; v.pos[i] = p; v.neg[i] = n;
         if (clr) begin
            acc_m[i] = 32'd0; sticky_m[i] = 1'b0;
         end else if (op[1]) begin
            acc_m[i] = r; sticky_m[i] = sticky_m[i] | p | n;
         end
         v.acc[i] = acc_m[i]; v.sticky[i] = sticky_m[i];
      end
      return v;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h7FFF_FFFF;
         1: return 32'h8000_0000;
         2: return 32'd0;
         3: return 32'hFFFF_FFFF;
         4: return 32'd1;
         default: return $urandom;
      endcase
   endfunction

   task automatic run(input vec_t v, input string tag);
      int guard;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = v.op; cmd_a = v.a; cmd_b = v.b;
      guard = 0;
      while (cmd_ready[0] !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check({tag, "/ready_wait"}, 32'(guard < 20), 32'd1);
      if (guard >= 20) begin
         cmd_valid = 1'b0;
         return;
      end
      @(negedge clk);  // accept edge has passed
      cmd_valid = 1'b0;
      cmd_op = 2'($urandom); cmd_a = $urandom; cmd_b = $urandom;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s/d%0d/ready_busy", tag, i), 32'(cmd_ready[i]), 32'd0);
         check($sformatf("%s/d%0d/valid_e1", tag, i), 32'(rsp_valid[i]), 32'd0);
         check($sformatf("%s/d%0d/alu_b", tag, i), alu_b[i], v.b);
         check($sformatf("%s/d%0d/alu_sub", tag, i), 32'(alu_sub[i]), 32'(v.op[0]));
         if (!v.op[1]) check($sformatf("%s/d%0d/alu_a", tag, i), alu_a[i], v.a);
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++)
         check($sformatf("%s/d%0d/valid_e2", tag, i), 32'(rsp_valid[i]), 32'd0);
      if (v.clr) acc_clear = 1'b1;
      @(negedge clk);  // capture edge has passed
      acc_clear = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s/d%0d/valid", tag, i), 32'(rsp_valid[i]), 32'd1);
         check($sformatf("%s/d%0d/result", tag, i), rsp_result[i], v.res[i]);
         check($sformatf("%s/d%0d/pos", tag, i), 32'(rsp_pos_ovf[i]), 32'(v.pos[i]));
         check($sformatf("%s/d%0d/neg", tag, i), 32'(rsp_neg_ovf[i]), 32'(v.neg[i]));
         check($sformatf("%s/d%0d/acc", tag, i), acc_value[i], v.acc[i]);
         check($sformatf("%s/d%0d/sticky", tag, i), 32'(sticky_ovf[i]), 32'(v.sticky[i]));
      end
      for (int s = 0; s < v.stall; s++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            check($sformatf("%s/d%0d/hold_valid", tag, i), 32'(rsp_valid[i]), 32'd1);
            check($sformatf("%s/d%0d/hold_result", tag, i), rsp_result[i], v.res[i]);
            check($sformatf("%s/d%0d/hold_ready", tag, i), 32'(cmd_ready[i]), 32'd0);
         end
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s/d%0d/valid_drop", tag, i), 32'(rsp_valid[i]), 32'd0);
         check($sformatf("%s/d%0d/ready_back", tag, i), 32'(cmd_ready[i]), 32'd1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl [12];
      vec_t v;
      int   guard;

      tbl[0]  = mk(2'b00, 32'd5,         32'd7,         0, 1'b0, 32'd12,        32'd12,        2'b00, 2'b00, 32'd0,         32'd0,         2'b00);
      tbl[1]  = mk(2'b01, 32'd3,         32'd10,        4, 1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 2'b00, 2'b00, 32'd0,         32'd0,         2'b00);
      tbl[2]  = mk(2'b10, 32'hDEAD_BEEF, 32'h7FFF_FFFF, 0, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 2'b00, 2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 2'b00);
      tbl[3]  = mk(2'b10, 32'hDEAD_BEEF, 32'd1,         1, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 2'b11, 2'b00, 32'h8000_0000, 32'h7FFF_FFFF, 2'b11);
      tbl[4]  = mk(2'b10, 32'd0,         32'd9,         0, 1'b1, 32'h8000_0009, 32'h7FFF_FFFF, 2'b10, 2'b00, 32'd0,         32'd0,         2'b00);
      tbl[5]  = mk(2'b10, 32'd0,         32'd9,         0, 1'b1, 32'd9,         32'd9,         2'b00, 2'b00, 32'd0,         32'd0,         2'b00);
      tbl[6]  = mk(2'b10, 32'd0,         32'h8000_0000, 0, 1'b0, 32'h8000_0000, 32'h8000_0000, 2'b00, 2'b00, 32'h8000_0000, 32'h8000_0000, 2'b00);
      tbl[7]  = mk(2'b11, 32'h1234_5678, 32'd1,         0, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 2'b00, 2'b11, 32'h7FFF_FFFF, 32'h8000_0000, 2'b11);
      tbl[8]  = mk(2'b00, 32'h7FFF_FFFF, 32'd1,         2, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 2'b11, 2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 2'b11);
      tbl[9]  = mk(2'b01, 32'd0,         32'd0,         2, 1'b0, 32'd0,         32'd0,         2'b00, 2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 2'b11);
      tbl[10] = mk(2'b11, 32'd0,         32'd0,         0, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 2'b00, 2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 2'b11);
      tbl[11] = mk(2'b01, 32'h8000_0000, 32'd1,         1, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 2'b00, 2'b11, 32'h7FFF_FFFF, 32'h8000_0000, 2'b11);

      rst_n = 1'b1;
      cmd_valid = 1'b0; rsp_ready = 1'b0; acc_clear = 1'b0;
      cmd_op = 2'b00; cmd_a = '0; cmd_b = '0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("rst/d%0d/ready", i), 32'(cmd_ready[i]), 32'd0);
         check($sformatf("rst/d%0d/valid", i), 32'(rsp_valid[i]), 32'd0);
         check($sformatf("rst/d%0d/acc", i), acc_value[i], 32'd0);
         check($sformatf("rst/d%0d/alu_a", i), alu_a[i], 32'd0);
      end
      rst_n = 1'b1;
      #1;
      for (int i = 0; i < 2; i++)
         check($sformatf("rel/d%0d/ready_low", i), 32'(cmd_ready[i]), 32'd0);
      @(negedge clk);
      for (int i = 0; i < 2; i++)
         check($sformatf("rel/d%0d/ready_high", i), 32'(cmd_ready[i]), 32'd1);

      for (int k = 0; k < 12; k++) run(tbl[k], $sformatf("vec%0d", k));

      // Clear while idle, then random traffic against the reference model.
      @(negedge clk);
      acc_clear = 1'b1;
      @(negedge clk);
      acc_clear = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("idle_clr/d%0d/acc", i), acc_value[i], 32'd0);
         check($sformatf("idle_clr/d%0d/sticky", i), 32'(sticky_ovf[i]), 32'd0);
         acc_m[i] = 32'd0; sticky_m[i] = 1'b0;
      end
      for (int k = 0; k < 40; k++) begin
         v = predict(2'($urandom_range(0, 3)), pick(), pick(), $urandom_range(0, 3),
                     ($urandom_range(0, 7) == 0));
         run(v, $sformatf("rnd%0d", k));
      end

      // Reset asserted while a command is in ISSUE.
      v = predict(2'b00, 32'd0, 32'd0, 0, 1'b0);
      run(predict(2'b10, 32'd0, 32'h0000_1234, 0, 1'b0), "pre_rst");
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'b10; cmd_b = 32'd5;
      guard = 0;
      while (cmd_ready[0] !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("mid_rst/ready_wait", 32'(guard < 20), 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("mid_rst/d%0d/valid", i), 32'(rsp_valid[i]), 32'd0);
         check($sformatf("mid_rst/d%0d/acc", i), acc_value[i], 32'd0);
         check($sformatf("mid_rst/d%0d/sticky", i), 32'(sticky_ovf[i]), 32'd0);
         check($sformatf("mid_rst/d%0d/ready", i), 32'(cmd_ready[i]), 32'd0);
         check($sformatf("mid_rst/d%0d/alu_b", i), alu_b[i], 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      for (int i = 0; i < 2; i++)
         check($sformatf("mid_rel/d%0d/ready_low", i), 32'(cmd_ready[i]), 32'd0);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("mid_rel/d%0d/ready_high", i), 32'(cmd_ready[i]), 32'd1);
         check($sformatf("mid_rel/d%0d/valid", i), 32'(rsp_valid[i]), 32'd0);
         acc_m[i] = 32'd0; sticky_m[i] = 1'b0;
      end
      run(predict(2'b10, 32'hFFFF_0000, 32'd3, 1, 1'b0), "post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
